// File: rtl/demux_1x8_stream_if.sv
// Valid/ready bundle for the 1-to-N stream demultiplexer: one input stream with
// a destination select, and NUM_OUT output streams.
interface demux_1x8_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 8
);
  localparam int SEL_WIDTH = $clog2(NUM_OUT);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [SEL_WIDTH-1:0]  s_sel;
  logic [NUM_OUT-1:0]    m_valid;
  logic [NUM_OUT-1:0]    m_ready;
  logic [DATA_WIDTH-1:0] m_data [NUM_OUT];

  // Producer/consumer side (drives s_*, m_ready)
  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );

  // Demultiplexer side
  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/demux_1x8_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer with a one-beat skid buffer.
// Beats leave strictly in arrival order; a stalled port blocks all others.
module demux_1x8_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1x8_stream_if.slave  bus
);
  localparam int SEL_WIDTH = $clog2(NUM_OUT);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_WIDTH-1:0]  main_sel_q, main_sel_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_WIDTH-1:0]  skid_sel_q, skid_sel_d;

  logic                  main_valid;
  logic                  in_fire;
  logic                  out_fire;
  logic [NUM_OUT-1:0]    port_hit;

  // s_ready and main_valid decode straight from the state flop, so no input
  // can reach them combinationally.
  assign main_valid  = (state_q != ST_EMPTY);
  assign bus.s_ready = (state_q != ST_FULL);
  assign in_fire     = bus.s_valid & (state_q != ST_FULL);
  assign out_fire    = main_valid & bus.m_ready[main_sel_q];

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_data_d = bus.s_data;
          main_sel_d  = bus.s_sel;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_data_d = bus.s_data;
          main_sel_d  = bus.s_sel;
        end else if (in_fire) begin
          skid_data_d = bus.s_data;
          skid_sel_d  = bus.s_sel;
          state_d     = ST_FULL;
        end else if (out_fire) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

  // Idle ports present all-zero data rather than a copy of the head beat.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_port
    assign port_hit[gi]    = main_valid & (main_sel_q == SEL_WIDTH'(gi));
    assign bus.m_valid[gi] = port_hit[gi];
    assign bus.m_data[gi]  = port_hit[gi] ? main_data_q : '0;
  end

endmodule

// File: tb/tb_demux_1x8_stream.sv
// Directed-vector bench for demux_1x8_stream; each task checks its own scenario.
module tb_demux_1x8_stream;
  localparam int DW = 32;
  localparam int NO = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_1x8_stream_if #(.DATA_WIDTH(DW), .NUM_OUT(NO)) bus_if ();

  demux_1x8_stream #(.DATA_WIDTH(DW), .NUM_OUT(NO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are settled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_data_zero(input string tag);
    for (int i = 0; i < NO; i++) begin
      checks++;
      if (bus_if.m_data[i] !== '0) begin
        errors++;
        $display("FAIL %s m_data[%0d]: got %h expected 0", tag, i, bus_if.m_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_sel   = '0;
    bus_if.m_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b expected 1", bus_if.s_ready);
    end
    checks++;
    if (bus_if.m_valid !== 8'h00) begin
      errors++;
      $display("FAIL reset_m_valid: got %h expected 00", bus_if.m_valid);
    end
    check_all_data_zero("reset");
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus_if.m_ready = 8'hFF;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 32'hA5A5_0001;
    bus_if.s_sel   = 3'd5;
    tick();
    bus_if.s_valid = 1'b0;
    checks++;
    if (bus_if.m_valid !== 8'b0010_0000) begin
      errors++;
      $display("FAIL single_m_valid: got %b expected 00100000", bus_if.m_valid);
    end
    checks++;
    if (bus_if.m_data[5] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_m_data5: got %h expected a5a50001", bus_if.m_data[5]);
    end
    for (int i = 0; i < NO; i++) begin
      if (i != 5) begin
        checks++;
        if (bus_if.m_data[i] !== '0) begin
          errors++;
          $display("FAIL single_other_data[%0d]: got %h expected 0", i, bus_if.m_data[i]);
        end
      end
    end
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h00 || bus_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: m_valid %h s_ready %b expected 00/1",
               bus_if.m_valid, bus_if.s_ready);
    end
    $display("test_single: beat a5a50001 -> port 5");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  exp_v;
    bus_if.m_ready = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      d              = 32'h1000_0000 + 32'(i);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = d;
      bus_if.s_sel   = 3'(i % 8);
      checks++;
      if (bus_if.s_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_s_ready beat %0d: got %b expected 1", i, bus_if.s_ready);
      end
      tick();
      exp_v = 8'h01 << (i % 8);
      checks++;
      if (bus_if.m_valid !== exp_v || bus_if.m_data[i % 8] !== d) begin
        errors++;
        $display("FAIL stream_out beat %0d: m_valid %h data %h expected %h/%h",
                 i, bus_if.m_valid, bus_if.m_data[i % 8], exp_v, d);
      end
      $display("stream beat %0d: port %0d data %h", i, i % 8, bus_if.m_data[i % 8]);
    end
    bus_if.s_valid = 1'b0;
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h00) begin
      errors++;
      $display("FAIL stream_drain: got %h expected 00", bus_if.m_valid);
    end
  endtask

  task automatic test_backpressure();
    bus_if.m_ready = 8'h00;
    bus_if.s_valid = 1'b1;
    bus_if.s_sel   = 3'd2;
    bus_if.s_data  = 32'h0000_00B1;
    tick();
    checks++;
    if (bus_if.s_ready !== 1'b1 || bus_if.m_valid !== 8'h04) begin
      errors++;
      $display("FAIL bp_beat1: s_ready %b m_valid %h expected 1/04", bus_if.s_ready, bus_if.m_valid);
    end
    bus_if.s_data = 32'h0000_00B2;
    tick();
    checks++;
    if (bus_if.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_s_ready: got %b expected 0", bus_if.s_ready);
    end
    bus_if.s_data = 32'h0000_00B3;
    tick();
    checks++;
    if (bus_if.s_ready !== 1'b0 || bus_if.m_data[2] !== 32'h0000_00B1) begin
      errors++;
      $display("FAIL bp_hold: s_ready %b data %h expected 0/000000b1", bus_if.s_ready, bus_if.m_data[2]);
    end
    bus_if.m_ready = 8'h04;
    tick();
    checks++;
    if (bus_if.m_data[2] !== 32'h0000_00B2 || bus_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: data %h s_ready %b expected 000000b2/1", bus_if.m_data[2], bus_if.s_ready);
    end
    tick();
    bus_if.s_valid = 1'b0;
    checks++;
    if (bus_if.m_valid !== 8'h04 || bus_if.m_data[2] !== 32'h0000_00B3) begin
      errors++;
      $display("FAIL bp_third: m_valid %h data %h expected 04/000000b3", bus_if.m_valid, bus_if.m_data[2]);
    end
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h00) begin
      errors++;
      $display("FAIL bp_drain: got %h expected 00", bus_if.m_valid);
    end
    $display("test_backpressure: b1,b2,b3 delivered on port 2");
  endtask

  task automatic test_head_of_line();
    bus_if.m_ready = 8'h40;
    bus_if.s_valid = 1'b1;
    bus_if.s_sel   = 3'd1;
    bus_if.s_data  = 32'hC000_0001;
    tick();
    bus_if.s_sel  = 3'd6;
    bus_if.s_data = 32'hC000_0006;
    tick();
    bus_if.s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_if.m_ready = (8'($urandom) & 8'hBD) | 8'h40;
      tick();
      checks++;
      if (bus_if.m_valid !== 8'h02 || bus_if.m_data[1] !== 32'hC000_0001 ||
          bus_if.m_data[6] !== 32'h0) begin
        errors++;
        $display("FAIL hol_blocked cyc %0d: m_valid %h d1 %h d6 %h expected 02/c0000001/0",
                 k, bus_if.m_valid, bus_if.m_data[1], bus_if.m_data[6]);
      end
    end
    bus_if.m_ready = 8'h42;
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h40 || bus_if.m_data[6] !== 32'hC000_0006 ||
        bus_if.m_data[1] !== 32'h0) begin
      errors++;
      $display("FAIL hol_release: m_valid %h d6 %h d1 %h expected 40/c0000006/0",
               bus_if.m_valid, bus_if.m_data[6], bus_if.m_data[1]);
    end
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h00) begin
      errors++;
      $display("FAIL hol_drain: got %h expected 00", bus_if.m_valid);
    end
    $display("test_head_of_line: port 6 waited for port 1");
  endtask

  task automatic test_input_stability();
    bus_if.m_ready = 8'h00;
    bus_if.s_valid = 1'b1;
    bus_if.s_sel   = 3'd0;
    bus_if.s_data  = 32'hD000_0000;
    tick();
    bus_if.s_data = 32'hD000_0001;
    tick();
    bus_if.s_sel  = 3'd3;
    bus_if.s_data = 32'hE000_0003;
    tick();
    bus_if.s_sel  = 3'd7;
    bus_if.s_data = 32'hE000_0007;
    tick();
    bus_if.m_ready = 8'h01;
    bus_if.s_sel   = 3'd3;
    bus_if.s_data  = 32'hE000_0033;
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h01 || bus_if.m_data[0] !== 32'hD000_0001) begin
      errors++;
      $display("FAIL stab_skid: m_valid %h d0 %h expected 01/d0000001", bus_if.m_valid, bus_if.m_data[0]);
    end
    bus_if.s_sel  = 3'd7;
    bus_if.s_data = 32'hF000_0007;
    tick();
    bus_if.s_valid = 1'b0;
    checks++;
    if (bus_if.m_valid !== 8'h80 || bus_if.m_data[7] !== 32'hF000_0007 ||
        bus_if.m_data[3] !== 32'h0) begin
      errors++;
      $display("FAIL stab_accept: m_valid %h d7 %h d3 %h expected 80/f0000007/0",
               bus_if.m_valid, bus_if.m_data[7], bus_if.m_data[3]);
    end
    bus_if.m_ready = 8'h80;
    tick();
    checks++;
    if (bus_if.m_valid !== 8'h00) begin
      errors++;
      $display("FAIL stab_drain: got %h expected 00", bus_if.m_valid);
    end
    $display("test_input_stability: only accepting-cycle values delivered");
  endtask

  task automatic test_reset_mid();
    bus_if.m_ready = 8'h00;
    bus_if.s_valid = 1'b1;
    bus_if.s_sel   = 3'd4;
    bus_if.s_data  = 32'h7700_0001;
    tick();
    bus_if.s_data = 32'h7700_0002;
    tick();
    bus_if.s_valid = 1'b0;
    checks++;
    if (bus_if.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full: s_ready %b expected 0", bus_if.s_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus_if.m_valid !== 8'h00 || bus_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: m_valid %h s_ready %b expected 00/1", bus_if.m_valid, bus_if.s_ready);
    end
    check_all_data_zero("rstmid");
    bus_if.m_ready = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus_if.m_valid !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_ghost cyc %0d: m_valid %h expected 00", k, bus_if.m_valid);
      end
    end
    $display("test_reset_mid: buffered beats discarded");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_head_of_line();
    test_input_stability();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x8_stream.md
Name: demux_1x8_stream

Overview:
- Stream demultiplexer: the distribution-side counterpart of the datapath mux4x1/mux8x1 selectors.
- Accepts one valid/ready input stream whose beats carry a destination select, and routes each beat to exactly one of NUM_OUT valid/ready output streams.
- Fully registered (output register plus skid register), so both m_valid/m_data and s_ready are flop outputs.
- Used where a shared producer fans out to per-lane consumers; preserves strict input order across all outputs.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- NUM_OUT, 8, number of output ports; power of two, >= 2.
- SEL_WIDTH, $clog2(NUM_OUT), localparam, width of the destination select.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input can accept; registered.
- s_data  input  DATA_WIDTH  input payload.
- s_sel  input  SEL_WIDTH  destination port index for the beat.
- m_valid  output  NUM_OUT  per-port valid; at most one bit set.
- m_ready  input  NUM_OUT  per-port ready.
- m_data  output  [DATA_WIDTH-1:0] x NUM_OUT (unpacked array)  per-port payload.

Behaviour:
- Transfers: in_fire = s_valid & s_ready. out_fire = main_valid & m_ready[main_sel].
- Storage: main register (data, sel, valid) drives the outputs; skid register (data, sel) holds one extra beat.
- m_valid[i] = main_valid & (main_sel == i).
- m_data[i] = main_data when m_valid[i], else all-zero.
- Once asserted, m_valid[i] and m_data[i] stay stable until out_fire; no retraction.
- State machine, registered:
  - EMPTY: main and skid empty; s_ready=1.
  - BUSY: main full, skid empty; s_ready=1.
  - FULL: main and skid full; s_ready=0.
- Transitions:
  - EMPTY: in_fire -> load main from s_*, go BUSY. Otherwise stay.
  - BUSY, in_fire & out_fire: main <= s_*, stay BUSY. This gives full throughput, 1 beat/cycle.
  - BUSY, in_fire only: skid <= s_*, go FULL.
  - BUSY, out_fire only: go EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main <= skid, go BUSY. No input accepted in FULL.
  - FULL, no out_fire: hold everything.
- Latency: a beat accepted in cycle N appears on m_valid[s_sel] in cycle N+1 when it enters an empty main register.
- Ordering: strictly in order. Head-of-line blocking is intended: a stalled port blocks beats for all other ports.
- s_sel and s_data are sampled only on in_fire; changes while s_ready=0 have no effect.
- m_ready bits of unselected ports are ignored.
- Reset (rst_n=0 at a clock edge):
  - state -> EMPTY, m_valid -> 0, m_data -> 0, s_ready -> 1 (first cycle after reset release), main and skid data -> 0.
  - Applies mid-transfer: buffered beats are discarded and no partial output is produced.
- No combinational path from m_ready or s_valid to s_ready, m_valid or m_data.

Test Plan:
- Single beat: s_data=0xA5A5_0001, s_sel=5, all m_ready=1 -> m_valid=8'b0010_0000 and m_data[5]=0xA5A5_0001 exactly 1 cycle later; other m_data=0; returns to EMPTY next cycle.
- Streaming: 16 back-to-back beats with sel cycling 0..7, all m_ready=1 -> one output beat per cycle, in order, each on the correct port; s_ready never drops.
- Backpressure: 3 beats to port 2 with m_ready[2]=0 -> beats 1 and 2 accepted, s_ready=0 from the cycle after beat 2. Raise m_ready[2] -> beats 1, 2, 3 emerge on port 2 in order with no loss or duplication.
- Head-of-line blocking: beat to port 1 (m_ready[1]=0) then beat to port 6 (m_ready[6]=1) -> port 6 stays idle until port 1 fires; m_ready of unselected ports toggled randomly has no effect.
- Input stability: hold s_valid=1 while FULL and change s_sel 3 -> 7 and s_data each cycle -> only the values present on the accepting cycle are delivered.
- Reset mid-operation: reach FULL, then drive rst_n=0 for one edge -> m_valid=0, all m_data=0, s_ready=1 the cycle after release; buffered beats never appear.
